// File: rtl/trigger_sequencer.sv
// trigger_sequencer: chains single-cycle trigger pulses into one capture trigger,
// each stage gated by a [min,max] gap window. Fail counter: TRIG_SEQ_FAIL_COUNT_EN.
module trigger_sequencer #(
   parameter int pNUM_TRIGGERS = 4,
   parameter int pWINDOW_WIDTH = 16
) (
   input  logic                                         adc_sampleclk,
   input  logic                                         reset,
   input  logic                                         armed_and_ready,
   input  logic                                         active,
   input  logic [pNUM_TRIGGERS-1:0]                     trigger_in,
   input  logic [2:0]                                   cfg_last_stage,
   input  logic [(pNUM_TRIGGERS-1)*pWINDOW_WIDTH-1:0]   cfg_window_min,
   input  logic [(pNUM_TRIGGERS-1)*pWINDOW_WIDTH-1:0]   cfg_window_max,
   output logic                                         trigger,
   output logic [2:0]                                   stage,
   output logic [1:0]                                   seq_state,
   output logic                                         fail,
   output logic [15:0]                                  fail_count
);

   localparam int CFGW = (pNUM_TRIGGERS-1)*pWINDOW_WIDTH;
   localparam logic [2:0] LAST_MAX = 3'(pNUM_TRIGGERS-1);
   localparam logic [pWINDOW_WIDTH-1:0] ONES = '1;
   localparam logic [pWINDOW_WIDTH-1:0] ONE =
      {{(pWINDOW_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_WAIT_FIRST = 2'd1,
      S_WAIT_NEXT  = 2'd2,
      S_DONE       = 2'd3
   } state_e;

   state_e                     state_q, state_d;
   logic [2:0]                 stage_q, stage_d;
   logic [pWINDOW_WIDTH-1:0]   cnt_q, cnt_d;
   logic                       trig_q, trig_d;
   logic                       fail_q, fail_d;
   logic [2:0]                 last_q, last_d;
   logic [CFGW-1:0]            min_q, min_d;
   logic [CFGW-1:0]            max_q, max_d;

   logic                       running;
   logic                       ev;
   logic [pWINDOW_WIDTH-1:0]   win_min;
   logic [pWINDOW_WIDTH-1:0]   win_max;
   logic [pWINDOW_WIDTH-1:0]   min_eff;
   logic [pWINDOW_WIDTH-1:0]   gap;
   logic [pWINDOW_WIDTH-1:0]   gap_next;
   logic                       in_window;
   logic                       timeout;

   assign running = active & armed_and_ready;

   // Select the awaited source bit and its window bounds for the current stage.
   always_comb begin
      ev      = 1'b0;
      win_min = '0;
      win_max = '0;
      for (int k = 0; k < pNUM_TRIGGERS; k++) begin
         if (stage_q == 3'(k)) ev = trigger_in[k];
      end
      for (int k = 1; k < pNUM_TRIGGERS; k++) begin
         if (stage_q == 3'(k)) begin
            win_min = min_q[(k-1)*pWINDOW_WIDTH +: pWINDOW_WIDTH];
            win_max = max_q[(k-1)*pWINDOW_WIDTH +: pWINDOW_WIDTH];
         end
      end
   end

   // Gap of an event this cycle, and of one arriving next cycle (both saturating).
   always_comb begin
      gap       = (cnt_q == ONES) ? ONES : cnt_q + ONE;
      gap_next  = (gap == ONES) ? ONES : gap + ONE;
      min_eff   = (win_min == '0) ? ONE : win_min;
      in_window = (gap >= min_eff) && (gap <= win_max);
      timeout   = gap_next > win_max;
   end

   // Next-state and registered-output logic of the sequencing FSM.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      cnt_d   = cnt_q;
      trig_d  = 1'b0;
      fail_d  = 1'b0;
      last_d  = last_q;
      min_d   = min_q;
      max_d   = max_q;
      if (!running) begin
         state_d = S_IDLE;
         stage_d = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               last_d  = (cfg_last_stage > LAST_MAX) ?
                         LAST_MAX : cfg_last_stage;
               min_d   = cfg_window_min;
               max_d   = cfg_window_max;
               state_d = S_WAIT_FIRST;
               stage_d = '0;
               cnt_d   = '0;
            end
            S_WAIT_FIRST: begin
               // A stage-0 pulse coinciding with a fail pulse is discarded.
               if (trigger_in[0] && !fail_q) begin
                  if (last_q == 3'd0) begin
                     trig_d  = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     stage_d = 3'd1;
                     cnt_d   = '0;
                     state_d = S_WAIT_NEXT;
                  end
               end
            end
            S_WAIT_NEXT: begin
               cnt_d = gap;
               if (ev && in_window) begin
                  if (stage_q == last_q) begin
                     trig_d  = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     stage_d = stage_q + 3'd1;
                     cnt_d   = '0;
                  end
               end else if (ev || timeout) begin
                  fail_d  = 1'b1;
                  state_d = S_WAIT_FIRST;
                  stage_d = '0;
                  cnt_d   = '0;
               end
            end
            S_DONE: begin
               state_d = S_DONE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Sequencer state and configuration registers.
   always_ff @(posedge adc_sampleclk) begin
      if (reset) begin
         state_q <= S_IDLE;
         stage_q <= '0;
         cnt_q   <= '0;
         trig_q  <= 1'b0;
         fail_q  <= 1'b0;
         last_q  <= '0;
         min_q   <= '0;
         max_q   <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
         trig_q  <= trig_d;
         fail_q  <= fail_d;
         last_q  <= last_d;
         min_q   <= min_d;
         max_q   <= max_d;
      end
   end

   assign trigger   = trig_q;
   assign stage     = stage_q;
   assign seq_state = state_q;
   assign fail      = fail_q;

`ifdef TRIG_SEQ_FAIL_COUNT_EN
   logic [15:0] fcnt_q, fcnt_d;

   // Saturating fail tally, cleared whenever a new arming starts.
   always_comb begin
      fcnt_d = fcnt_q;
      if (running && state_q == S_IDLE) begin
         fcnt_d = '0;
      end else if (fail_d && fcnt_q != 16'hFFFF) begin
         fcnt_d = fcnt_q + 16'd1;
      end
   end

   // Fail counter register.
   always_ff @(posedge adc_sampleclk) begin
      if (reset) fcnt_q <= '0;
      else       fcnt_q <= fcnt_d;
   end

   assign fail_count = fcnt_q;
`else
   assign fail_count = '0;
`endif

endmodule

// File: tb/tb_trigger_sequencer.sv
// tb_trigger_sequencer: directed test-plan scenarios plus randomized traffic,
// checked every cycle against a gap-timestamp model of the sequencer.
module tb_trigger_sequencer;

   localparam int N    = 4;
   localparam int W    = 16;
   localparam int CW   = (N-1)*W;
   localparam longint ONES = 65535;
`ifdef TRIG_SEQ_FAIL_COUNT_EN
   localparam bit FC_EN = 1'b1;
`else
   localparam bit FC_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          armed_and_ready;
   logic          active;
   logic [N-1:0]  trigger_in;
   logic [2:0]    cfg_last_stage;
   logic [CW-1:0] cfg_window_min;
   logic [CW-1:0] cfg_window_max;
   logic          trigger;
   logic [2:0]    stage;
   logic [1:0]    seq_state;
   logic          fail;
   logic [15:0]   fail_count;

   always #5 clk = ~clk;

   trigger_sequencer #(
      .pNUM_TRIGGERS(N),
      .pWINDOW_WIDTH(W)
   ) dut (
      .adc_sampleclk   (clk),
      .reset           (reset),
      .armed_and_ready (armed_and_ready),
      .active          (active),
      .trigger_in      (trigger_in),
      .cfg_last_stage  (cfg_last_stage),
      .cfg_window_min  (cfg_window_min),
      .cfg_window_max  (cfg_window_max),
      .trigger         (trigger),
      .stage           (stage),
      .seq_state       (seq_state),
      .fail            (fail),
      .fail_count      (fail_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input longint act,
                        input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Behavioural model: tracks the cycle of the last accepted stage and
   // derives gaps from timestamps.
   int     m_mode;
   int     m_stage;
   int     m_last;
   longint m_tacc;
   longint cyc = 0;
   longint m_min [N];
   longint m_max [N];
   bit     m_trig;
   bit     m_fail;
   int     m_fc;
   int     m_ntrig = 0;
   longint gap;
   longint lo;
   longint hi;
   bit     trignow;
   bit     failnow;

   always @(posedge clk) begin
      if (reset) begin
         m_mode  = 0;
         m_stage = 0;
         m_last  = 0;
         m_tacc  = 0;
         m_trig  = 0;
         m_fail  = 0;
         m_fc    = 0;
         for (int k = 0; k < N; k++) begin
            m_min[k] = 0;
            m_max[k] = 0;
         end
      end else begin
         trignow = 0;
         failnow = 0;
         if (!(active && armed_and_ready)) begin
            m_mode  = 0;
            m_stage = 0;
         end else begin
            case (m_mode)
               0: begin
                  m_last = (int'(cfg_last_stage) > N-1) ?
                           N-1 : int'(cfg_last_stage);
                  for (int k = 0; k < N-1; k++) begin
                     m_min[k+1] = longint'(cfg_window_min[k*W +: W]);
                     m_max[k+1] = longint'(cfg_window_max[k*W +: W]);
                  end
                  m_mode  = 1;
                  m_stage = 0;
                  m_fc    = 0;
               end
               1: begin
                  if (trigger_in[0] && !m_fail) begin
                     if (m_last == 0) begin
                        trignow = 1;
                        m_mode  = 3;
                     end else begin
                        m_stage = 1;
                        m_tacc  = cyc;
                        m_mode  = 2;
                     end
                  end
               end
               2: begin
                  gap = cyc - m_tacc;
                  if (gap > ONES) gap = ONES;
                  lo = (m_min[m_stage] == 0) ? 1 : m_min[m_stage];
                  hi = m_max[m_stage];
                  if (trigger_in[m_stage]) begin
                     if (gap >= lo && gap <= hi) begin
                        if (m_stage == m_last) begin
                           trignow = 1;
                           m_mode  = 3;
                        end else begin
                           m_stage++;
                           m_tacc = cyc;
                        end
                     end else begin
                        failnow = 1;
                     end
                  end else if (hi != ONES && gap >= hi) begin
                     failnow = 1;
                  end
               end
               default: ;
            endcase
         end
         if (failnow) begin
            m_mode  = 1;
            m_stage = 0;
            if (m_fc < 65535) m_fc++;
         end
         if (trignow) m_ntrig++;
         m_trig = trignow;
         m_fail = failnow;
      end
      cyc++;
      #1;
      check("trigger", trigger, m_trig);
      check("fail", fail, m_fail);
      check("stage", stage, m_stage);
      check("seq_state", seq_state, m_mode);
      check("fail_count", fail_count, FC_EN ? m_fc : 0);
   end

   task automatic step(input logic [N-1:0] tin);
      trigger_in = tin;
      @(negedge clk);
      trigger_in = '0;
   endtask

   task automatic set_cfg(input int last, input int mn0, input int mn1,
                          input int mn2, input int mx0, input int mx1,
                          input int mx2);
      cfg_last_stage = 3'(last);
      cfg_window_min = {W'(mn2), W'(mn1), W'(mn0)};
      cfg_window_max = {W'(mx2), W'(mx1), W'(mx0)};
   endtask

   task automatic rearm();
      armed_and_ready = 1'b0;
      step('0);
      armed_and_ready = 1'b1;
      step('0);
   endtask

   task automatic rand_cfg();
      int mn;
      int r;
      cfg_last_stage = ($urandom_range(0, 5) == 0) ?
                       3'($urandom_range(0, 7)) : 3'($urandom_range(1, 3));
      for (int k = 0; k < N-1; k++) begin
         mn = $urandom_range(0, 6);
         r  = $urandom_range(0, 9);
         cfg_window_min[k*W +: W] = W'(mn);
         if (r == 0)
            cfg_window_max[k*W +: W] = '1;
         else if (r == 1)
            cfg_window_max[k*W +: W] = W'((mn > 0) ? mn - 1 : 0);
         else
            cfg_window_max[k*W +: W] = W'(mn + $urandom_range(0, 12));
      end
   endtask

   bit            saw_fail;
   logic [N-1:0]  tin;

   initial begin
      reset           = 1'b1;
      active          = 1'b0;
      armed_and_ready = 1'b0;
      trigger_in      = '0;
      set_cfg(0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      check("rst_trigger", trigger, 0);
      check("rst_stage", stage, 0);
      check("rst_state", seq_state, 0);
      check("rst_fail", fail, 0);
      check("rst_fail_count", fail_count, 0);
      reset = 1'b0;
      @(negedge clk);

      // single-stage sequence
      active          = 1'b1;
      armed_and_ready = 1'b1;
      step('0);
      check("t1_wait_first", seq_state, 1);
      repeat (8) step('0);
      step(4'b0001);
      check("t1_trigger", trigger, 1);
      check("t1_done", seq_state, 3);
      step('0);
      check("t1_trigger_once", trigger, 0);
      step(4'b0001);
      check("t1_no_retrigger", trigger, 0);
      check("t1_still_done", seq_state, 3);

      // three-stage sequence within windows
      set_cfg(2, 5, 3, 0, 20, 10, 0);
      rearm();
      step(4'b0001);
      check("t2_stage1", stage, 1);
      check("t2_wait_next", seq_state, 2);
      for (int i = 0; i < 5; i++) begin
         step('0);
         check("t2_stage1_hold", stage, 1);
      end
      step(4'b0010);
      check("t2_stage2", stage, 2);
      step('0);
      step('0);
      step(4'b0100);
      check("t2_trigger", trigger, 1);
      check("t2_done", seq_state, 3);

      // early events fail, then a valid sequence still triggers
      rearm();
      for (int i = 0; i < 3; i++) begin
         step(4'b0001);
         repeat (3) step('0);
         step(4'b0010);
         check("t3_fail", fail, 1);
         check("t3_stage0", stage, 0);
         check("t3_wait_first", seq_state, 1);
         step('0);
         check("t3_fail_once", fail, 0);
      end
      check("t3_fail_count", fail_count, FC_EN ? 3 : 0);
      step(4'b0001);
      repeat (5) step('0);
      step(4'b0010);
      repeat (2) step('0);
      step(4'b0100);
      check("t3_trigger", trigger, 1);
      check("t3_fc_hold", fail_count, FC_EN ? 3 : 0);
      rearm();
      check("t3_fc_clear", fail_count, 0);

      // timeout after gap 20
      step(4'b0001);
      repeat (19) step('0);
      check("t4_no_fail_yet", fail, 0);
      step('0);
      check("t4_timeout_fail", fail, 1);
      check("t4_wait_first", seq_state, 1);

      // all-ones max never times out; saturated gap is still accepted
      set_cfg(2, 5, 3, 0, 65535, 10, 0);
      rearm();
      step(4'b0001);
      saw_fail = 1'b0;
      repeat (66000) begin
         step('0);
         if (fail) saw_fail = 1'b1;
      end
      check("t4b_no_fail", saw_fail, 0);
      check("t4b_wait_next", seq_state, 2);
      step(4'b0010);
      check("t4b_sat_accept", stage, 2);
      repeat (2) step('0);
      step(4'b0100);
      check("t4b_trigger", trigger, 1);

      // disarm mid-sequence, re-arm latches new config
      set_cfg(2, 5, 3, 0, 20, 10, 0);
      rearm();
      step(4'b0001);
      repeat (2) step('0);
      check("t5_wait_next", seq_state, 2);
      armed_and_ready = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0, 0);
      step('0);
      check("t5_idle", seq_state, 0);
      check("t5_no_trigger", trigger, 0);
      check("t5_no_fail", fail, 0);
      armed_and_ready = 1'b1;
      step('0);
      check("t5_rearm_state", seq_state, 1);
      check("t5_rearm_stage", stage, 0);
      step(4'b0001);
      check("t5_relatched", trigger, 1);

      // min=0 acts as min=1
      set_cfg(1, 0, 0, 0, 2, 0, 0);
      rearm();
      step(4'b0001);
      step(4'b0010);
      check("t6_min0_trigger", trigger, 1);

      // randomized traffic
      for (int i = 0; i < 8000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            if ($urandom_range(0, 1) == 0) armed_and_ready = 1'b0;
            else                           active = 1'b0;
            rand_cfg();
            repeat ($urandom_range(1, 3)) step('0);
            armed_and_ready = 1'b1;
            active          = 1'b1;
         end
         if ($urandom_range(0, 49) == 0) rand_cfg();
         for (int k = 0; k < N; k++)
            tin[k] = ($urandom_range(0, 3) == 0);
         step(tin);
      end
      check("rand_triggers_seen", (m_ntrig > 10) ? 1 : 0, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
